// File: rtl/rdma_recv_if.sv
// rdma_recv bus bundle: parser address/data streams in, AXI4 write master out.
// master = the rdma_recv block, slave = the parser/memory side around it.
interface rdma_recv_if #(
  parameter int AXI_DATA_WIDTH = 512,
  parameter int AXI_ADDR_WIDTH = 64
);
  localparam int KW = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] AXIS_ADDR_TDATA;
  logic [7:0]                AXIS_ADDR_TUSER;
  logic                      AXIS_ADDR_TVALID;
  logic                      AXIS_ADDR_TREADY;

  logic [AXI_DATA_WIDTH-1:0] AXIS_DATA_TDATA;
  logic [KW-1:0]             AXIS_DATA_TKEEP;
  logic                      AXIS_DATA_TLAST;
  logic                      AXIS_DATA_TVALID;
  logic                      AXIS_DATA_TREADY;

  logic [AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [7:0]                M_AXI_AWLEN;
  logic [2:0]                M_AXI_AWSIZE;
  logic [1:0]                M_AXI_AWBURST;
  logic [3:0]                M_AXI_AWID;
  logic                      M_AXI_AWLOCK;
  logic [3:0]                M_AXI_AWCACHE;
  logic [2:0]                M_AXI_AWPROT;
  logic [3:0]                M_AXI_AWQOS;
  logic                      M_AXI_AWVALID;
  logic                      M_AXI_AWREADY;

  logic [AXI_DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [KW-1:0]             M_AXI_WSTRB;
  logic                      M_AXI_WLAST;
  logic                      M_AXI_WVALID;
  logic                      M_AXI_WREADY;

  logic [1:0]                M_AXI_BRESP;
  logic                      M_AXI_BVALID;
  logic                      M_AXI_BREADY;

  modport master (
    input  AXIS_ADDR_TDATA, AXIS_ADDR_TUSER, AXIS_ADDR_TVALID,
    output AXIS_ADDR_TREADY,
    input  AXIS_DATA_TDATA, AXIS_DATA_TKEEP, AXIS_DATA_TLAST,
    input  AXIS_DATA_TVALID,
    output AXIS_DATA_TREADY,
    output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
    output M_AXI_AWID, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT,
    output M_AXI_AWQOS, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  modport slave (
    output AXIS_ADDR_TDATA, AXIS_ADDR_TUSER, AXIS_ADDR_TVALID,
    input  AXIS_ADDR_TREADY,
    output AXIS_DATA_TDATA, AXIS_DATA_TKEEP, AXIS_DATA_TLAST,
    output AXIS_DATA_TVALID,
    input  AXIS_DATA_TREADY,
    input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
    input  M_AXI_AWID, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT,
    input  M_AXI_AWQOS, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );
endinterface

// File: rtl/rdma_recv.sv
// RDMA receive path: one address/data pair from the parser becomes one
// AXI4 INCR write burst, with an outstanding-response ceiling and error counters.
module rdma_recv #(
  parameter int AXI_DATA_WIDTH  = 512,
  parameter int AXI_ADDR_WIDTH  = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  rdma_recv_if.master bus,
  output logic [31:0] framing_errors,
  output logic [31:0] bresp_errors,
  output logic        idle
);
  localparam logic [2:0] SIZE    = 3'($clog2(AXI_DATA_WIDTH / 8));
  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                    state;
  state_t                    state_next;
  logic                      aw_valid;
  logic                      aw_done;
  logic                      w_done;
  logic                      frame_bad;
  logic                      addr_ready;
  logic                      b_ready;
  logic [7:0]                beat_cnt;
  logic [7:0]                aw_len;
  logic [7:0]                outstanding;
  logic [7:0]                out_next;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;

  logic in_burst;
  logic w_open;
  logic w_last;
  logic a_fire;
  logic aw_fire;
  logic w_fire;
  logic b_fire;
  logic leave;
  logic tlast_bad;

  assign in_burst = (state == BURST);
  assign w_open   = in_burst & ~w_done;
  assign w_last   = (beat_cnt == aw_len);
  assign a_fire   = addr_ready & bus.AXIS_ADDR_TVALID;
  assign aw_fire  = aw_valid & bus.M_AXI_AWREADY;
  assign w_fire   = bus.M_AXI_WVALID & bus.M_AXI_WREADY;
  assign b_fire   = bus.M_AXI_BVALID & b_ready;

  // AW and the last W beat may both complete in the same cycle.
  assign leave = in_burst
               & (aw_done | aw_fire)
               & (w_done | (w_fire & w_last));

  assign tlast_bad = w_last ? ~bus.AXIS_DATA_TLAST
                            : bus.AXIS_DATA_TLAST;

  assign out_next = outstanding + 8'(leave) - 8'(b_fire);

  always_comb begin
    state_next = state;
    unique case (1'b1)
      a_fire:  state_next = BURST;
      leave:   state_next = IDLE;
      default: ;
    endcase
  end

  assign bus.AXIS_ADDR_TREADY = addr_ready;
  assign bus.AXIS_DATA_TREADY = bus.M_AXI_WREADY & w_open;

  assign bus.M_AXI_AWADDR  = aw_addr;
  assign bus.M_AXI_AWLEN   = aw_len;
  assign bus.M_AXI_AWSIZE  = SIZE;
  assign bus.M_AXI_AWBURST = 2'b01;
  assign bus.M_AXI_AWID    = 4'd0;
  assign bus.M_AXI_AWLOCK  = 1'b0;
  assign bus.M_AXI_AWCACHE = 4'd0;
  assign bus.M_AXI_AWPROT  = 3'd0;
  assign bus.M_AXI_AWQOS   = 4'd0;
  assign bus.M_AXI_AWVALID = aw_valid;

  assign bus.M_AXI_WDATA  = bus.AXIS_DATA_TDATA;
  assign bus.M_AXI_WSTRB  = bus.AXIS_DATA_TKEEP;
  assign bus.M_AXI_WLAST  = w_last;
  assign bus.M_AXI_WVALID = bus.AXIS_DATA_TVALID & w_open;

  assign bus.M_AXI_BREADY = b_ready;

  assign idle = (state == IDLE) & (outstanding == 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      aw_valid       <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      frame_bad      <= 1'b0;
      addr_ready     <= 1'b0;
      b_ready        <= 1'b0;
      beat_cnt       <= 8'd0;
      aw_len         <= 8'd0;
      aw_addr        <= '0;
      outstanding    <= 8'd0;
      framing_errors <= 32'd0;
      bresp_errors   <= 32'd0;
    end else begin
      state       <= state_next;
      outstanding <= out_next;
      b_ready     <= 1'b1;
      addr_ready  <= (state_next == IDLE) && (out_next < MAX_OUT);

      if (a_fire) begin
        aw_addr   <= bus.AXIS_ADDR_TDATA;
        aw_len    <= bus.AXIS_ADDR_TUSER;
        beat_cnt  <= 8'd0;
        aw_valid  <= 1'b1;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
        frame_bad <= 1'b0;
      end

      if (aw_fire) begin
        aw_valid <= 1'b0;
        aw_done  <= 1'b1;
      end

      if (w_fire) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (w_last)
          w_done <= 1'b1;
        // One framing error per burst, however many beats disagree.
        if (tlast_bad && !frame_bad) begin
          framing_errors <= framing_errors + 32'd1;
          frame_bad      <= 1'b1;
        end
      end

      if (b_fire && bus.M_AXI_BRESP != 2'b00)
        bresp_errors <= bresp_errors + 32'd1;
    end
  end
endmodule

// File: tb/tb_rdma_recv.sv
// Scoreboard bench for rdma_recv: expected AW/W traffic is queued at issue
// time and a negedge monitor pops and compares on each handshake.
module tb_rdma_recv;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rdma_recv_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) bus();

  logic [31:0] framing_errors;
  logic [31:0] bresp_errors;
  logic        idle;

  rdma_recv #(
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .framing_errors(framing_errors),
    .bresp_errors(bresp_errors),
    .idle(idle)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } aw_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  aw_t        addr_q[$];
  aw_t        exp_aw[$];
  beat_t      data_q[$];
  beat_t      exp_w[$];
  logic [1:0] bresp_q[$];

  int checks = 0;
  int errors = 0;
  int aw_cnt = 0;
  int w_cnt = 0;
  int wl_cnt = 0;
  int b_sent = 0;
  int aw_w_mark = 0;
  int aw_delay = 0;
  bit a_fire = 0;
  bit d_fire = 0;
  bit w_rand = 0;
  bit d_stall = 0;
  bit b_hold = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic burst(logic [AW-1:0] addr, logic [7:0] len, int nb,
                       int tl_idx, logic [31:0] base, logic [1:0] resp);
    aw_t a;
    beat_t b;
    a.addr = addr;
    a.len  = len;
    addr_q.push_back(a);
    exp_aw.push_back(a);
    bresp_q.push_back(resp);
    for (int i = 0; i < nb; i++) begin
      b.data = {16{base + 32'(i)}};
      b.keep = {8{8'(i * 37 + 1)}};
      b.last = (tl_idx >= 0) ? (i == tl_idx) : (i == nb - 1);
      data_q.push_back(b);
      b.last = (i == int'(len));
      exp_w.push_back(b);
    end
  endtask

  task automatic wait_done(string name, int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (n < budget && !(exp_aw.size() == 0 && exp_w.size() == 0 &&
           addr_q.size() == 0 && idle && !bus.M_AXI_BVALID)) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n < budget), 64'd1);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    aw_t e;
    beat_t w;
    a_fire = bus.AXIS_ADDR_TVALID & bus.AXIS_ADDR_TREADY;
    d_fire = bus.AXIS_DATA_TVALID & bus.AXIS_DATA_TREADY;
    if (!reset && bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
      aw_cnt++;
      aw_w_mark = w_cnt;
      if (exp_aw.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL aw_unexpected: got addr %0h expected none",
                 bus.M_AXI_AWADDR);
      end else begin
        e = exp_aw.pop_front();
        chk("awaddr", bus.M_AXI_AWADDR, e.addr);
        chk("awlen", 64'(bus.M_AXI_AWLEN), 64'(e.len));
        chk("awsize", 64'(bus.M_AXI_AWSIZE), 64'd6);
        chk("awburst", 64'(bus.M_AXI_AWBURST), 64'd1);
      end
    end
    if (!reset && bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
      w_cnt++;
      if (bus.M_AXI_WLAST) wl_cnt++;
      if (exp_w.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w_unexpected: got beat %0h expected none",
                 bus.M_AXI_WDATA[31:0]);
      end else begin
        w = exp_w.pop_front();
        checks++;
        if (bus.M_AXI_WDATA !== w.data) begin
          errors++;
          $display("FAIL wdata: got %0h expected %0h",
                   bus.M_AXI_WDATA[31:0], w.data[31:0]);
        end
        chk("wstrb", bus.M_AXI_WSTRB, w.keep);
        chk("wlast", 64'(bus.M_AXI_WLAST), 64'(w.last));
      end
    end
  end

  // Address stream source
  initial begin
    aw_t a;
    bus.AXIS_ADDR_TVALID = 1'b0;
    bus.AXIS_ADDR_TDATA  = '0;
    bus.AXIS_ADDR_TUSER  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || a_fire) bus.AXIS_ADDR_TVALID = 1'b0;
      if (!reset && !bus.AXIS_ADDR_TVALID && addr_q.size() > 0) begin
        a = addr_q.pop_front();
        bus.AXIS_ADDR_TDATA  = a.addr;
        bus.AXIS_ADDR_TUSER  = a.len;
        bus.AXIS_ADDR_TVALID = 1'b1;
      end
    end
  end

  // Data stream source
  initial begin
    beat_t b;
    bus.AXIS_DATA_TVALID = 1'b0;
    bus.AXIS_DATA_TDATA  = '0;
    bus.AXIS_DATA_TKEEP  = '0;
    bus.AXIS_DATA_TLAST  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || d_fire) bus.AXIS_DATA_TVALID = 1'b0;
      if (!reset && !bus.AXIS_DATA_TVALID && data_q.size() > 0 &&
          (!d_stall || $urandom_range(0, 1) == 1)) begin
        b = data_q.pop_front();
        bus.AXIS_DATA_TDATA  = b.data;
        bus.AXIS_DATA_TKEEP  = b.keep;
        bus.AXIS_DATA_TLAST  = b.last;
        bus.AXIS_DATA_TVALID = 1'b1;
      end
    end
  end

  // AXI slave: AW delay, W ready pattern, in-order B responses
  initial begin
    int aw_wait;
    int owed;
    aw_wait = 0;
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && bus.M_AXI_AWVALID) begin
        if (aw_wait >= aw_delay) begin
          bus.M_AXI_AWREADY = 1'b1;
        end else begin
          bus.M_AXI_AWREADY = 1'b0;
          aw_wait++;
        end
      end else begin
        bus.M_AXI_AWREADY = 1'b0;
        aw_wait = 0;
      end
      bus.M_AXI_WREADY = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      owed = ((aw_cnt < wl_cnt) ? aw_cnt : wl_cnt) - b_sent;
      if (bus.M_AXI_BVALID) begin
        bus.M_AXI_BVALID = 1'b0;
        b_sent++;
      end else if (!reset && !b_hold && owed > 0 && bresp_q.size() > 0) begin
        bus.M_AXI_BRESP  = bresp_q.pop_front();
        bus.M_AXI_BVALID = 1'b1;
      end
    end
  end

  initial begin
    int base;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_awvalid", 64'(bus.M_AXI_AWVALID), 64'd0);
    chk("rst_wvalid", 64'(bus.M_AXI_WVALID), 64'd0);
    chk("rst_addr_tready", 64'(bus.AXIS_ADDR_TREADY), 64'd0);
    chk("rst_data_tready", 64'(bus.AXIS_DATA_TREADY), 64'd0);
    chk("rst_bready", 64'(bus.M_AXI_BREADY), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_framing", 64'(framing_errors), 64'd0);
    chk("rst_bresp", 64'(bresp_errors), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("run_bready", 64'(bus.M_AXI_BREADY), 64'd1);
    chk("run_addr_tready", 64'(bus.AXIS_ADDR_TREADY), 64'd1);

    // Single-beat burst
    burst(64'h1000, 8'd0, 1, -1, 32'h1000_0000, 2'b00);
    wait_done("t1_done", 200);
    chk("t1_framing", 64'(framing_errors), 64'd0);
    chk("t1_bresp", 64'(bresp_errors), 64'd0);
    chk("t1_idle", 64'(idle), 64'd1);

    // W beats run ahead of a delayed AW handshake
    aw_delay = 5;
    base = w_cnt;
    burst(64'h2000, 8'd3, 4, -1, 32'h2000_0000, 2'b00);
    wait_done("t2_done", 200);
    chk("t2_w_before_aw", 64'(aw_w_mark - base), 64'd4);
    aw_delay = 0;

    // Random WREADY and TVALID stalls
    w_rand = 1;
    d_stall = 1;
    base = w_cnt;
    burst(64'h3000, 8'd7, 8, -1, 32'h3000_0000, 2'b00);
    wait_done("t3_done", 500);
    chk("t3_beats", 64'(w_cnt - base), 64'd8);
    w_rand = 0;
    d_stall = 0;

    // Early TLAST (and missing TLAST on the real last beat) counts once
    burst(64'h4000, 8'd3, 4, 1, 32'h4000_0000, 2'b00);
    burst(64'h5000, 8'd0, 1, -1, 32'h5000_0000, 2'b00);
    wait_done("t4_done", 200);
    chk("t4_framing", 64'(framing_errors), 64'd1);

    // Outstanding ceiling of 2 with B withheld
    b_hold = 1;
    base = aw_cnt;
    burst(64'h6000, 8'd0, 1, -1, 32'h6000_0000, 2'b00);
    burst(64'h6040, 8'd0, 1, -1, 32'h6040_0000, 2'b00);
    burst(64'h6080, 8'd0, 1, -1, 32'h6080_0000, 2'b00);
    repeat (30) @(negedge clk);
    chk("t5_aw_held", 64'(aw_cnt - base), 64'd2);
    chk("t5_addr_tready", 64'(bus.AXIS_ADDR_TREADY), 64'd0);
    chk("t5_idle", 64'(idle), 64'd0);
    b_hold = 0;
    wait_done("t5_done", 200);
    chk("t5_aw_all", 64'(aw_cnt - base), 64'd3);

    // One SLVERR among three responses
    burst(64'h7000, 8'd1, 2, -1, 32'h7000_0000, 2'b00);
    burst(64'h7100, 8'd0, 1, -1, 32'h7100_0000, 2'b10);
    burst(64'h7200, 8'd0, 1, -1, 32'h7200_0000, 2'b00);
    wait_done("t6_done", 300);
    chk("t6_bresp", 64'(bresp_errors), 64'd1);

    // Reset in the middle of a burst
    aw_delay = 100;
    base = w_cnt;
    burst(64'h8000, 8'd3, 2, -1, 32'h8000_0000, 2'b00);
    n = 0;
    while (n < 100 && w_cnt - base < 2) begin
      @(negedge clk);
      n++;
    end
    chk("t7_partial", 64'(n < 100), 64'd1);
    chk("t7_awvalid_mid", 64'(bus.M_AXI_AWVALID), 64'd1);
    #2;
    addr_q.delete();
    exp_aw.delete();
    data_q.delete();
    exp_w.delete();
    bresp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("t7_awvalid", 64'(bus.M_AXI_AWVALID), 64'd0);
    chk("t7_wvalid", 64'(bus.M_AXI_WVALID), 64'd0);
    chk("t7_addr_tready", 64'(bus.AXIS_ADDR_TREADY), 64'd0);
    chk("t7_data_tready", 64'(bus.AXIS_DATA_TREADY), 64'd0);
    chk("t7_bready", 64'(bus.M_AXI_BREADY), 64'd0);
    chk("t7_idle", 64'(idle), 64'd1);
    chk("t7_framing", 64'(framing_errors), 64'd0);
    chk("t7_bresp", 64'(bresp_errors), 64'd0);
    aw_delay = 0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Recovery after reset
    burst(64'h9000, 8'd0, 1, -1, 32'h9000_0000, 2'b00);
    wait_done("t8_done", 200);
    chk("t8_framing", 64'(framing_errors), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rdma_recv.md
# rdma_recv

Receive-side counterpart of the RDMA transmit path. Consumes an address/length stream and a data stream (produced by the packet parser from incoming RDMA frames) and turns each address/data pair into one AXI4 INCR write burst on an AXI-MM master port. Tracks outstanding write responses, limits them to a configurable ceiling, and counts framing and response errors for status registers.

## Interface
Parameters:
- AXI_DATA_WIDTH, 512, width of W data and of the data stream; AWSIZE = log2(AXI_DATA_WIDTH/8)
- AXI_ADDR_WIDTH, 64, width of AWADDR and of the address stream
- MAX_OUTSTANDING, 4, maximum AW bursts issued without a B response (1..255)

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- AXIS_ADDR_TDATA  in  AXI_ADDR_WIDTH  byte address of the burst
- AXIS_ADDR_TUSER  in  8  burst length minus one (becomes AWLEN)
- AXIS_ADDR_TVALID / AXIS_ADDR_TREADY  in / out  1  address-stream handshake
- AXIS_DATA_TDATA  in  AXI_DATA_WIDTH  payload beat
- AXIS_DATA_TKEEP  in  AXI_DATA_WIDTH/8  byte enables, become WSTRB
- AXIS_DATA_TLAST  in  1  end of packet, checked only, never forwarded
- AXIS_DATA_TVALID / AXIS_DATA_TREADY  in / out  1  data-stream handshake
- M_AXI_AWADDR  out  AXI_ADDR_WIDTH; M_AXI_AWLEN out 8; M_AXI_AWSIZE out 3; M_AXI_AWBURST out 2 (=01); M_AXI_AWID out 4 (=0); M_AXI_AWLOCK, AWCACHE, AWPROT, AWQOS out (all 0)
- M_AXI_AWVALID / M_AXI_AWREADY  out / in  1
- M_AXI_WDATA out AXI_DATA_WIDTH; M_AXI_WSTRB out AXI_DATA_WIDTH/8; M_AXI_WLAST out 1
- M_AXI_WVALID / M_AXI_WREADY  out / in  1
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1
- framing_errors  out  32  count of TLAST/beat-count mismatches
- bresp_errors  out  32  count of B responses with BRESP != 0
- idle  out  1  no burst in progress and no responses outstanding

## Operation
- States: IDLE, BURST.
- IDLE: AXIS_ADDR_TREADY = 1 when outstanding < MAX_OUTSTANDING. On address handshake: latch AWADDR = TDATA, AWLEN = TUSER, beat counter = 0, set AWVALID, go to BURST.
- BURST: AWVALID held until AWREADY handshake, then cleared (registered, never re-asserted in the same burst).
- W channel is a combinational pass-through gated by state: WVALID = AXIS_DATA_TVALID & in BURST & !w_done; AXIS_DATA_TREADY = M_AXI_WREADY & in BURST & !w_done; WDATA/WSTRB = TDATA/TKEEP.
- WLAST = (beat counter == AWLEN); generated locally, independent of TLAST. W beats may precede the AW handshake.
- Each W handshake increments beat counter; the WLAST beat sets w_done.
- Framing check on WLAST beat: TLAST must be 1; on any earlier beat TLAST must be 0. Each violation increments framing_errors by 1 (at most one per burst); burst length is never altered.
- Leave BURST -> IDLE when AW handshake done and w_done (both may complete in the same cycle). Outstanding counter increments on that transition.
- BREADY = 1 whenever not in reset. Each B handshake decrements outstanding; BRESP != 0 increments bresp_errors.
- Simultaneous increment and decrement of outstanding: net unchanged.
- Error counters wrap at 2^32.

## Timing
- Reset values: state IDLE, AWVALID 0, WVALID 0, AXIS_ADDR_TREADY 0, AXIS_DATA_TREADY 0, BREADY 0, outstanding 0, both error counters 0, idle 1 (first cycle after reset).
- Address accepted in cycle N -> AWVALID and W gating open in cycle N+1.
- W path adds zero latency; throughput one beat per cycle.
- Back-to-back bursts: one IDLE cycle minimum between bursts.
- Reset asserted mid-burst: everything returns to reset values next cycle; partially sent burst is abandoned (downstream slave is reset with this block).
- idle = (state == IDLE) & (outstanding == 0), registered inputs only.

## Test plan
- Address 0x1000, TUSER 0, one data beat with TLAST=1 -> AWADDR 0x1000, AWLEN 0, AWSIZE 6, one W beat with WLAST=1, BRESP 0 -> idle returns to 1, both error counters 0.
- Address 0x2000, TUSER 3, AWREADY delayed 5 cycles, data valid immediately -> all 4 W beats pass before AW handshake, WLAST only on beat 4, data order preserved.
- TUSER 7 with random WREADY and TVALID stalls (50%) -> 8 beats in order, WSTRB equals TKEEP each beat, no beat duplicated or dropped.
- TUSER 3 with TLAST on beat 2 and then TUSER 0 with TLAST=1 -> first burst still 4 W beats, framing_errors = 1.
- MAX_OUTSTANDING 2, slave withholds BVALID, three addresses queued -> two AW bursts issued, AXIS_ADDR_TREADY low until first BVALID, then third burst issues.
- Slave returns BRESP 2 on one of three bursts -> bresp_errors = 1; reset asserted mid-burst -> all outputs at reset values next cycle.
